// File: rtl/block_to_raster_reorder_pkg.sv
// Shared constants for the 8x8 block-order to raster-order plane copier.
package block_to_raster_reorder_pkg;

  // Block geometry: 8x8 pixels, two pixels per memory word.
  localparam int BLK_DIM           = 8;
  localparam int WORDS_PER_BLK_ROW = 4;
  localparam int WORDS_PER_BLK     = 32;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/block_to_raster_reorder_addr_gen.sv
// Address generator: walks by/bx/r/c and produces the linear source address
// plus the raster destination address from add-only accumulators.
module reorder_addr_gen
  import block_to_raster_reorder_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic              adv_i,
  input  logic [14:0]       stride_i,
  input  logic [12:0]       bh_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic              last_o
);

  localparam logic [1:0] C_MAX = 2'(WORDS_PER_BLK_ROW - 1);
  localparam logic [2:0] R_MAX = 3'(BLK_DIM - 1);

  logic [1:0]        c_q, c_d;
  logic [2:0]        r_q, r_d;
  logic [12:0]       bx_q, bx_d, by_q, by_d;
  logic [12:0]       bw_max_q, bw_max_d, bh_max_q, bh_max_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] src_q, src_d;
  // row_q: first word of the current pixel row inside the current block.
  // col_q: row-0 word of the current block. brow_q: origin of the block row.
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, brow_q, brow_d;

  assign src_addr_o = src_q;
  assign dst_addr_o = row_q + ADDR_W'(c_q);
  assign last_o     = (c_q == C_MAX) && (r_q == R_MAX) &&
                      (bx_q == bw_max_q) && (by_q == bh_max_q);

  // Next-state: load on start of pass, otherwise step one word per issue.
  always_comb begin
    c_d      = c_q;
    r_d      = r_q;
    bx_d     = bx_q;
    by_d     = by_q;
    bw_max_d = bw_max_q;
    bh_max_d = bh_max_q;
    stride_d = stride_q;
    src_d    = src_q;
    row_d    = row_q;
    col_d    = col_q;
    brow_d   = brow_q;
    if (init_i) begin
      c_d      = '0;
      r_d      = '0;
      bx_d     = '0;
      by_d     = '0;
      bw_max_d = stride_i[14:2] - 13'd1;
      bh_max_d = bh_i - 13'd1;
      stride_d = ADDR_W'(stride_i);
      src_d    = src_base_i;
      row_d    = dst_base_i;
      col_d    = dst_base_i;
      brow_d   = dst_base_i;
    end else if (adv_i) begin
      src_d = src_q + ADDR_W'(1);
      if (c_q != C_MAX) begin
        c_d = c_q + 2'd1;
      end else begin
        c_d = '0;
        if (r_q != R_MAX) begin
          r_d   = r_q + 3'd1;
          row_d = row_q + stride_q;
        end else begin
          r_d = '0;
          if (bx_q != bw_max_q) begin
            // Next block to the right: four words further along row 0.
            bx_d  = bx_q + 13'd1;
            col_d = col_q + ADDR_W'(WORDS_PER_BLK_ROW);
            row_d = col_q + ADDR_W'(WORDS_PER_BLK_ROW);
          end else begin
            // Next block row: eight raster rows further down.
            bx_d   = '0;
            by_d   = (by_q != bh_max_q) ? by_q + 13'd1 : '0;
            brow_d = brow_q + (stride_q << 3);
            col_d  = brow_q + (stride_q << 3);
            row_d  = brow_q + (stride_q << 3);
          end
        end
      end
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      r_q      <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      bw_max_q <= '0;
      bh_max_q <= '0;
      stride_q <= '0;
      src_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      brow_q   <= '0;
    end else begin
      c_q      <= c_d;
      r_q      <= r_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      bw_max_q <= bw_max_d;
      bh_max_q <= bh_max_d;
      stride_q <= stride_d;
      src_q    <= src_d;
      row_q    <= row_d;
      col_q    <= col_d;
      brow_q   <= brow_d;
    end
  end

endmodule

// File: rtl/block_to_raster_reorder.sv
// Copies one colour plane from 8x8-block order to raster order, one word
// per cycle: a read every RUN cycle, the matching write one cycle later.
module block_to_raster_reorder
  import block_to_raster_reorder_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state_q, state_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic              init, last;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              size_zero;

  assign size_zero = (width == 16'd0) || (height == 16'd0);
  assign init      = (state_q == ST_IDLE) && start && !size_zero;

  reorder_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst),
    .init_i     (init),
    .adv_i      (rd_en),
    .stride_i   (width[15:1]),
    .bh_i       (height[15:3]),
    .src_base_i (src_base),
    .dst_base_i (dst_base),
    .src_addr_o (src_addr),
    .dst_addr_o (dst_addr),
    .last_o     (last)
  );

  assign rd_en  = (state_q == ST_RUN);
  assign r_addr = src_addr;
  assign wr_en  = wr_en_q;
  assign w_addr = w_addr_q;
  // Read data lands the cycle after the request, which is the write cycle,
  // so it is forwarded straight through; gating keeps it zero when idle.
  assign wdata  = wr_en_q ? r_data : '0;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

  // Pass sequencing; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = size_zero ? ST_DONE : ST_RUN;
      ST_RUN:   if (last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and the one-stage write pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= rd_en;
      if (rd_en) w_addr_q <= dst_addr;
    end
  end

endmodule

// File: tb/tb_block_to_raster_reorder.sv
// Directed bench for block_to_raster_reorder with a one-cycle-latency memory.
module tb_block_to_raster_reorder;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] width, height;
  logic [17:0] src_base, dst_base, r_addr, w_addr;
  logic        rd_en, wr_en, busy, done;
  logic [15:0] r_data, wdata;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic clr_log = 1'b0;
  logic mem_init = 1'b0;
  logic [15:0] mem [1024];
  int   rda[$], rdc[$], wra[$], wrd[$], wrc[$], dnc[$];
  int   busy_n = 0;

  always #5 clk = ~clk;

  block_to_raster_reorder dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .src_base(src_base), .dst_base(dst_base), .rd_en(rd_en), .r_addr(r_addr),
    .r_data(r_data), .wr_en(wr_en), .w_addr(w_addr), .wdata(wdata),
    .busy(busy), .done(done)
  );

  function automatic logic [15:0] pat(input int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  // Raster destination of source word k, straight from the block geometry.
  function automatic int dst_of(input int k, input int w, input int db);
    int bw, blk, by, bx, r, c;
    bw  = w / 8;
    blk = k / 32;
    by  = blk / bw;
    bx  = blk % bw;
    r   = (k % 32) / 4;
    c   = k % 4;
    return db + (8 * by + r) * (w / 2) + 4 * bx + c;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (wr_en) begin
      mem[w_addr[9:0]] <= wdata;
    end
    if (rd_en) r_data <= mem[r_addr[9:0]];
  end

  always @(negedge clk) begin
    if (clr_log) begin
      rda.delete(); rdc.delete(); wra.delete(); wrd.delete(); wrc.delete(); dnc.delete();
      busy_n <= 0;
    end else begin
      if (rd_en) begin rda.push_back(int'(r_addr)); rdc.push_back(cyc - t0); end
      if (wr_en) begin
        wra.push_back(int'(w_addr)); wrd.push_back(int'(wdata)); wrc.push_back(cyc - t0);
      end
      if (done) dnc.push_back(cyc - t0);
      if (busy) busy_n <= busy_n + 1;
    end
  end

  // mode 0: plain pass; 1: extra start pulses; 2: reset dropped at cycle 10
  task automatic run(input int w, input int h, input int sb, input int db,
                     input int mode, input int ncyc);
    int n;
    n = w * h / 2;
    width = 16'(w); height = 16'(h);
    src_base = 18'(sb); dst_base = 18'(db);
    for (int k = 0; k < ncyc; k++) begin
      start    = (k == 0) || (mode == 1 && (k == 5 || k == n + 2 || k == n + 3));
      clr_log  = (k == 0);
      mem_init = (k == 0);
      if (k == 0) t0 = cyc;
      if (mode == 2 && k == 10) begin
        rst = 1'b0;
        #1;
        chk("reset_mid_outputs",
            {rd_en, wr_en, busy, done, r_addr, w_addr, wdata}, 0);
      end
      if (mode == 2 && k == 13) rst = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; clr_log = 1'b0; mem_init = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int w, input int h,
                              input int sb, input int db);
    int n, bad, d;
    n = w * h / 2;
    bad = 0;
    for (int k = 0; k < n; k++)
      if (k >= rda.size() || rda[k] != sb + k || rdc[k] != k + 1) bad++;
    chk({tag, "_rd_order"}, bad, 0);
    bad = 0;
    for (int k = 0; k < n; k++)
      if (k >= wra.size() || wra[k] != dst_of(k, w, db) ||
          wrd[k] != int'(pat(sb + k)) || wrc[k] != k + 2) bad++;
    chk({tag, "_wr_order"}, bad, 0);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      d = dst_of(k, w, db);
      if (mem[d % 1024] != pat(sb + k)) bad++;
    end
    chk({tag, "_image"}, bad, 0);
  endtask

  task automatic check_single(input string tag, input int n);
    chk({tag, "_rd_count"}, rda.size(), n);
    chk({tag, "_wr_count"}, wra.size(), n);
    chk({tag, "_done_count"}, dnc.size(), 1);
    chk({tag, "_done_cycle"}, (dnc.size() > 0) ? dnc[0] : -1, n + 2);
    chk({tag, "_busy_cycles"}, busy_n, n + 2);
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0;
    width = 16'd0; height = 16'd0; src_base = '0; dst_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rd_en, wr_en, busy, done, r_addr, w_addr, wdata}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 8x8: reads 0..31, writes 100..131 in order
    run(8, 8, 0, 100, 0, 40);
    check_stream("p8x8", 8, 8, 0, 100);
    check_single("p8x8", 32);
    chk("p8x8_first_wr_addr", (wra.size() > 0) ? wra[0] : -1, 100);

    // 16x8: two blocks side by side
    run(16, 8, 0, 512, 0, 72);
    check_stream("p16x8", 16, 8, 0, 512);
    check_single("p16x8", 64);
    chk("p16x8_w4", mem[512 + 8], pat(4));
    chk("p16x8_w32", mem[512 + 4], pat(32));
    chk("p16x8_w36", mem[512 + 12], pat(36));
    chk("p16x8_w63", mem[512 + 63], pat(63));

    // 16x16: two block rows
    run(16, 16, 0, 512, 0, 136);
    check_stream("p16x16", 16, 16, 0, 512);
    check_single("p16x16", 128);
    chk("p16x16_w64", mem[512 + 64], pat(64));
    chk("p16x16_w96", mem[512 + 68], pat(96));
    chk("p16x16_w127", mem[512 + 127], pat(127));

    // Reset mid-pass, then a fresh full pass
    run(16, 16, 0, 512, 2, 24);
    bad = 0;
    foreach (wrc[i]) if (wrc[i] >= 10) bad++;
    chk("reset_no_wr_after", bad, 0);
    bad = 0;
    foreach (rdc[i]) if (rdc[i] >= 10) bad++;
    chk("reset_no_rd_after", bad, 0);
    chk("reset_no_done", dnc.size(), 0);
    run(16, 16, 8, 600, 0, 136);
    check_stream("after_rst", 16, 16, 8, 600);
    check_single("after_rst", 128);

    // Start pulses during RUN and DONE are ignored; IDLE start re-runs
    run(16, 8, 0, 512, 1, 145);
    check_stream("restart", 16, 8, 0, 512);
    chk("restart_done_count", dnc.size(), 2);
    chk("restart_done0", (dnc.size() > 0) ? dnc[0] : -1, 66);
    chk("restart_done1", (dnc.size() > 1) ? dnc[1] : -1, 133);
    chk("restart_rd_count", rda.size(), 128);
    chk("restart_rd2_cycle", (rdc.size() > 64) ? rdc[64] : -1, 68);
    chk("restart_busy_cycles", busy_n, 132);

    // Zero width: straight to DONE, no traffic
    run(0, 8, 0, 512, 0, 8);
    chk("zero_rd_count", rda.size(), 0);
    chk("zero_wr_count", wra.size(), 0);
    chk("zero_done_count", dnc.size(), 1);
    chk("zero_done_cycle", (dnc.size() > 0) ? dnc[0] : -1, 1);
    chk("zero_busy_cycles", busy_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
